wave_addr_gen: RTL and testbench

Initiator side of the wave-memory interface in the signal generator. A phase accumulator produces the en/addr stream that feeds the 8-bit-addressed, 10-bit-output wave memory. The memory's output qualifier (dout_en) lags its en by 2 clocks. Frequency comes from a tuning word, phase offset is a start-point rotation, and length is a whole number of waveform periods or continuous. Sits between the control/register logic and the wave memory.

---
 rtl/wave_addr_gen_pkg.sv | 16 +
 rtl/wave_addr_gen_if.sv | 34 +++
 rtl/wave_addr_gen_phase_acc.sv | 35 +++
 rtl/wave_addr_gen.sv | 147 ++++++++++++++
 tb/tb_wave_addr_gen.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wave_addr_gen_pkg.sv
// Shared definitions for the wave-memory address generator.
//   state_e : generator FSM states (idle / emitting samples / draining memory pipeline)
//   ADDR_W  : wave memory address width
//   MEM_LAT : wave memory en -> dout_en latency, default drain length
package wave_addr_gen_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned MEM_LAT = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

endpackage

// File: rtl/wave_addr_gen_if.sv
// Control + memory-request bundle of the wave address generator.
//   start/stop      : one-clock control pulses
//   fword/poff/cycles : configuration, sampled on the start clock only
//   en/addr         : wave memory request
//   busy/done       : status back to the control logic
// master: control/register side; slave: the generator.
interface wave_addr_gen_if
  import wave_addr_gen_pkg::*;
#(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 16
);

  logic              start;
  logic              stop;
  logic [ACC_W-1:0]  fword;
  logic [ADDR_W-1:0] poff;
  logic [CNT_W-1:0]  cycles;
  logic              en;
  logic [ADDR_W-1:0] addr;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, fword, poff, cycles,
    input  en, addr, busy, done
  );

  modport slave (
    input  start, stop, fword, poff, cycles,
    output en, addr, busy, done
  );

endinterface

// File: rtl/wave_addr_gen_phase_acc.sv
// Phase accumulator.
//   clk, rstn : clock, async active-low reset
//   clr       : synchronous clear (takes priority over inc)
//   inc       : add fword to acc this clock
//   fword     : tuning word
//   acc       : accumulator value
//   carry     : combinational carry-out of acc + fword (a period wraps this clock if inc)
module wave_addr_gen_phase_acc #(
  parameter int unsigned ACC_W = 24
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             inc,
  input  logic [ACC_W-1:0] fword,
  output logic [ACC_W-1:0] acc,
  output logic             carry
);

  logic [ACC_W:0] sum;

  assign sum   = {1'b0, acc} + {1'b0, fword};
  assign carry = sum[ACC_W];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (inc) begin
      acc <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/wave_addr_gen.sv
// Wave memory address generator (initiator side of the wave-memory interface).
//   clk, rstn : clock, async active-low reset
//   bus       : slave view of wave_addr_gen_if
//               in : start, stop, fword, poff, cycles
//               out: en, addr (memory request), busy, done (status)
// A phase accumulator stepped by the latched tuning word drives the address;
// the run ends after cyc_l full periods (or on stop), then waits DRAIN_LEN
// clocks for the memory pipeline before pulsing done.
module wave_addr_gen
  import wave_addr_gen_pkg::*;
#(
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DRAIN_LEN = MEM_LAT
) (
  input logic           clk,
  input logic           rstn,
  wave_addr_gen_if.slave bus
);

  localparam int unsigned DCNT_W = (DRAIN_LEN > 0) ? $clog2(DRAIN_LEN + 1) : 1;

  state_e state_q, state_d;

  logic [ACC_W-1:0]  fword_l_q;
  logic [ADDR_W-1:0] poff_l_q;
  logic [CNT_W-1:0]  cyc_l_q;
  logic              load;

  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;

  logic              en_q, en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              acc_clr, acc_inc;
  logic [ACC_W-1:0]  acc;
  logic              carry;
  logic              last_period;

  wave_addr_gen_phase_acc #(
    .ACC_W (ACC_W)
  ) u_phase_acc (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (acc_clr),
    .inc   (acc_inc),
    .fword (fword_l_q),
    .acc   (acc),
    .carry (carry)
  );

  // The sample being issued now closes the final requested period.
  assign last_period = carry && (cyc_l_q != '0) && (pcnt_q == cyc_l_q - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    dcnt_d  = dcnt_q;
    en_d    = 1'b0;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    acc_clr = 1'b0;
    acc_inc = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        // stop is deliberately not looked at here
        if (bus.start) begin
          load    = 1'b1;
          acc_clr = 1'b1;
          pcnt_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        en_d    = 1'b1;
        busy_d  = 1'b1;
        addr_d  = ADDR_W'(acc >> (ACC_W - ADDR_W)) + poff_l_q;
        acc_inc = 1'b1;
        if (carry) begin
          pcnt_d = pcnt_q + CNT_W'(1);
        end
        if (bus.stop || last_period) begin
          dcnt_d  = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        // DRAIN_LEN clocks with en low, then busy falls together with done
        if (dcnt_q == DCNT_W'(DRAIN_LEN)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      pcnt_q  <= '0;
      dcnt_q  <= '0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      dcnt_q  <= dcnt_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fword_l_q <= '0;
      poff_l_q  <= '0;
      cyc_l_q   <= '0;
    end else if (load) begin
      fword_l_q <= bus.fword;
      poff_l_q  <= bus.poff;
      cyc_l_q   <= bus.cycles;
    end
  end

  assign bus.en   = en_q;
  assign bus.addr = addr_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_wave_addr_gen.sv
// Self-checking bench for wave_addr_gen: directed scenarios plus randomized runs,
// every clock compared against a sample-list reference model.
module tb_wave_addr_gen;
  import wave_addr_gen_pkg::*;

  localparam int unsigned ACC_W     = 24;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned DRAIN_LEN = 2;
  localparam int          MAX_SAMP  = 6000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  wave_addr_gen_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  wave_addr_gen #(
    .ACC_W     (ACC_W),
    .CNT_W     (CNT_W),
    .DRAIN_LEN (DRAIN_LEN)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: on an accepted start, the complete list of addresses is
  // computed up front from phase arithmetic; a stop truncates the list.
  bit m_active = 0;
  int m_q[$];
  int m_drain = 0;
  int m_last = 0;
  bit e_en, e_busy, e_done;
  int e_addr;
  bit st, sp;
  int en_cnt = 0, busy_cnt = 0, done_cnt = 0;

  function automatic void gen(int unsigned fw, int unsigned po, int unsigned cy);
    longint      p = 0;
    longint      full = longint'(1) << ACC_W;
    int unsigned periods = 0;
    m_q.delete();
    for (int n = 0; n < MAX_SAMP; n++) begin
      m_q.push_back(int'(((p >> (ACC_W - 8)) + po) % 256));
      p += fw;
      if (p >= full) begin
        p -= full;
        periods++;
        if (cy != 0 && periods == cy) break;
      end
    end
  endfunction

  always @(posedge clk) begin
    st = bus.start;
    sp = bus.stop;
    e_done = 1'b0;
    if (!rstn) begin
      m_active = 0;
      m_q.delete();
      m_last = 0;
      e_en = 0; e_busy = 0; e_addr = 0;
    end else if (!m_active) begin
      e_en = 0; e_busy = 0; e_addr = m_last;
      if (st) begin
        gen(bus.fword, bus.poff, bus.cycles);
        m_active = 1;
      end
    end else if (m_q.size() > 0) begin
      e_en = 1; e_busy = 1;
      e_addr = m_q.pop_front();
      m_last = e_addr;
      if (sp || m_q.size() == 0) begin
        m_q.delete();
        m_drain = DRAIN_LEN;
      end
    end else if (m_drain > 0) begin
      e_en = 0; e_busy = 1; e_addr = m_last;
      m_drain--;
    end else begin
      e_en = 0; e_busy = 0; e_done = 1; e_addr = m_last;
      m_active = 0;
    end
    #1;
    check("en", bus.en, e_en);
    check("addr", bus.addr, e_addr);
    check("busy", bus.busy, e_busy);
    check("done", bus.done, e_done);
    if (bus.en) en_cnt++;
    if (bus.busy) busy_cnt++;
    if (bus.done) done_cnt++;
  end

  task automatic clr_cnt();
    en_cnt = 0; busy_cnt = 0; done_cnt = 0;
  endtask

  task automatic pulse_start(input int unsigned fw, input int unsigned po,
                             input int unsigned cy, input bit with_stop);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.stop   = with_stop;
    bus.fword  = fw[ACC_W-1:0];
    bus.poff   = po[7:0];
    bus.cycles = cy[CNT_W-1:0];
    @(negedge clk);
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.fword  = ACC_W'($urandom);
    bus.poff   = 8'($urandom);
    bus.cycles = CNT_W'($urandom);
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, done_cnt != 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int unsigned fw, po, cy, stop_at;
    bus.start = 0; bus.stop = 0; bus.fword = '0; bus.poff = '0; bus.cycles = '0;
    repeat (3) @(negedge clk);
    check("rst_en", bus.en, 0);
    check("rst_busy", bus.busy, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // one period, unit address step
    clr_cnt();
    pulse_start(32'h010000, 0, 1, 0);
    wait_done("t1_done", 400);
    check("t1_en_cnt", en_cnt, 256);
    check("t1_busy_cnt", busy_cnt, 258);
    check("t1_done_cnt", done_cnt, 1);

    // three periods with phase offset
    clr_cnt();
    pulse_start(32'h040000, 32'h40, 3, 0);
    wait_done("t2_done", 400);
    check("t2_en_cnt", en_cnt, 192);
    check("t2_busy_cnt", busy_cnt, 194);
    check("t2_done_cnt", done_cnt, 1);

    // continuous, ended by stop
    clr_cnt();
    pulse_start(32'h008000, 0, 0, 0);
    repeat (998) @(negedge clk);
    check("t3_no_done", done_cnt, 0);
    check("t3_en_live", bus.en, 1);
    pulse_stop();
    wait_done("t3_done", 20);
    check("t3_drain", busy_cnt - en_cnt, DRAIN_LEN);
    check("t3_done_cnt", done_cnt, 1);

    // start while busy ignored
    clr_cnt();
    pulse_start(32'h040000, 32'h10, 1, 0);
    repeat (20) @(negedge clk);
    pulse_start(32'h100000, 32'h99, 5, 0);
    wait_done("t4_done", 200);
    check("t4_en_cnt", en_cnt, 64);
    check("t4_done_cnt", done_cnt, 1);

    // start and stop together in idle
    clr_cnt();
    pulse_start(32'h080000, 0, 2, 1);
    wait_done("t5_done", 200);
    check("t5_en_cnt", en_cnt, 64);

    // asynchronous reset mid-run
    clr_cnt();
    pulse_start(32'h010000, 32'h22, 1, 0);
    repeat (100) @(negedge clk);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    check("ar_en", bus.en, 0);
    check("ar_addr", bus.addr, 0);
    check("ar_busy", bus.busy, 0);
    check("ar_done", bus.done, 0);
    repeat (3) @(negedge clk);
    check("ar_no_done", done_cnt, 0);
    rstn = 1'b1;
    clr_cnt();
    pulse_start(32'h010000, 0, 1, 0);
    wait_done("ar_t1_done", 400);
    check("ar_t1_en_cnt", en_cnt, 256);
    check("ar_t1_busy_cnt", busy_cnt, 258);

    // terminal-carry boundary with maximum tuning word
    clr_cnt();
    pulse_start(32'hFFFFFF, 32'h05, 2, 0);
    wait_done("ff2_done", 50);
    check("ff2_en_cnt", en_cnt, 3);
    clr_cnt();
    pulse_start(32'hFFFFFF, 32'h05, 1, 0);
    wait_done("ff1_done", 50);
    check("ff1_en_cnt", en_cnt, 2);

    // randomized runs
    for (int it = 0; it < 16; it++) begin
      fw = $urandom_range(32'h040000, 32'hFFFFFF);
      po = $urandom_range(0, 255);
      cy = $urandom_range(0, 3);
      stop_at = $urandom_range(2, 300);
      clr_cnt();
      pulse_start(fw, po, cy, $urandom_range(0, 1));
      for (int k = 0; k < int'(stop_at) && done_cnt == 0; k++) begin
        if (k == 5 && bus.en && $urandom_range(0, 1) == 1) begin
          pulse_start($urandom, $urandom, $urandom, 0);
        end else begin
          @(negedge clk);
        end
      end
      if (done_cnt == 0 && bus.en) pulse_stop();
      wait_done("rnd_done", 400);
      check("rnd_done_cnt", done_cnt, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
